// File: rtl/noise_reg_port.sv
// noise_reg_port -- CPU-side register write port for the APU noise channel.
//
// Decodes CPU writes to BASE_ADDR+0/+2/+3 ($400C/$400E/$400F) into a small
// write-event FIFO and hands each event to the noise channel over a
// valid/ack handshake. The channel-visible shadow bytes r400c/r400e/r400f
// only change when a handshake completes. Writes are never merged, because
// every $400F write must reload the channel's length counter. A write to
// $4015 updates noise_en (bit 3) directly and is not queued.
//
// Optional feature, macro NOISE_REG_READBACK_EN:
//   defined   -> a $4015 read returns {overflow,3'b0,len_nonzero,3'b0} in
//                cpu_rdata and clears overflow (a drop at the same edge wins).
//   undefined -> cpu_re/len_nonzero are ignored, cpu_rdata is 0, and
//                overflow clears only on rst.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   cpu_addr/wdata/we/re   CPU bus
//   cpu_rdata              registered $4015 read data
//   cpu_busy               queue full (a write presented now is dropped)
//   overflow               sticky: a queued-address write was dropped
//   wr_valid/sel/data/ack  queue head toward the channel (sel 0=$400C,1=$400E,2=$400F)
//   r400c/r400e/r400f      shadow registers consumed by the channel
//   noise_en               $4015 bit 3
//   len_nonzero            channel length counter != 0
module noise_reg_port #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h400C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_busy,
  output logic        overflow,
  output logic        wr_valid,
  output logic [1:0]  wr_sel,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  output logic [7:0]  r400c,
  output logic [7:0]  r400e,
  output logic [7:0]  r400f,
  output logic        noise_en,
  input  logic        len_nonzero
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] STATUS_ADDR = 16'h4015;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } wr_ent_t;

  wr_ent_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           r400c_q, r400e_q, r400f_q;
  logic                 noise_en_q;
  logic [7:0]           rdata_q;

  logic                 push_req, push, pop, drop, full;
  logic [1:0]           push_sel;
  wr_ent_t              head;

  // Address decode for queued registers; $400D and anything else is ignored.
  always_comb begin
    push_req = 1'b0;
    push_sel = 2'd0;
    if (cpu_we) begin
      if (cpu_addr == BASE_ADDR) begin
        push_req = 1'b1;
        push_sel = 2'd0;
      end else if (cpu_addr == BASE_ADDR + 16'd2) begin
        push_req = 1'b1;
        push_sel = 2'd1;
      end else if (cpu_addr == BASE_ADDR + 16'd3) begin
        push_req = 1'b1;
        push_sel = 2'd2;
      end
    end
  end

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign head     = fifo_q[rptr_q];
  assign wr_valid = (count_q != '0);
  // Fullness is judged before this edge's pop, so a push while full drops
  // even if the head leaves at the same edge.
  assign push     = push_req & ~full;
  assign drop     = push_req & full;
  assign pop      = wr_valid & wr_ack;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef NOISE_REG_READBACK_EN
  logic status_rd;
  assign status_rd = cpu_re & (cpu_addr == STATUS_ADDR);

  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (status_rd) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata_q <= '0;
    else if (status_rd) rdata_q <= {ovf_q, 3'b000, len_nonzero, 3'b000};
  end
`else
  logic unused_rb;
  assign unused_rb = cpu_re ^ len_nonzero;

  always_comb begin
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      r400c_q    <= '0;
      r400e_q    <= '0;
      r400f_q    <= '0;
      noise_en_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push) begin
        fifo_q[wptr_q] <= '{sel: push_sel, data: cpu_wdata};
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
        case (head.sel)
          2'd0:    r400c_q <= head.data;
          2'd1:    r400e_q <= head.data;
          2'd2:    r400f_q <= head.data;
          default: ;
        endcase
      end
      if (cpu_we && cpu_addr == STATUS_ADDR) noise_en_q <= cpu_wdata[3];
    end
  end

  assign cpu_busy  = full;
  assign overflow  = ovf_q;
  assign wr_sel    = head.sel;
  assign wr_data   = head.data;
  assign r400c     = r400c_q;
  assign r400e     = r400e_q;
  assign r400f     = r400f_q;
  assign noise_en  = noise_en_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_noise_reg_port.sv
module tb_noise_reg_port;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_we = 1'b0, cpu_re = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_busy, overflow, wr_valid;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        wr_ack = 1'b0;
  logic [7:0]  r400c, r400e, r400f;
  logic        noise_en;
  logic        len_nonzero = 1'b0;

  noise_reg_port #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(16'h400C)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
    .cpu_busy(cpu_busy), .overflow(overflow), .wr_valid(wr_valid),
    .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(wr_ack),
    .r400c(r400c), .r400e(r400e), .r400f(r400f),
    .noise_en(noise_en), .len_nonzero(len_nonzero)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Scoreboard of {sel,data} expected at the channel, plus a reference model.
  logic [9:0] sb[$];
  logic [7:0] m_c, m_e, m_f, m_rdata;
  logic       m_ovf, m_ne;
  int         hs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_c = '0; m_e = '0; m_f = '0; m_rdata = '0; m_ovf = 1'b0; m_ne = 1'b0;
  endtask

  // One clock: predict from pre-edge inputs, advance the model, compare.
  task automatic tick();
    bit         hs, pushq, drop, rd;
    logic [1:0] psel;
    hs    = (sb.size() != 0) && wr_ack;
    pushq = cpu_we && (cpu_addr == 16'h400C || cpu_addr == 16'h400E || cpu_addr == 16'h400F);
    psel  = (cpu_addr == 16'h400C) ? 2'd0 : (cpu_addr == 16'h400E) ? 2'd1 : 2'd2;
    drop  = pushq && (sb.size() == DEPTH);
    rd    = cpu_re && cpu_addr == 16'h4015;
    if (hs && !rst) check("head", {wr_sel, wr_data}, sb[0]);
    @(posedge clk); #1;
    if (rst) begin model_clear(); return; end
`ifdef NOISE_REG_READBACK_EN
    if (rd) m_rdata = {m_ovf, 3'b000, len_nonzero, 3'b000};
    if (drop) m_ovf = 1'b1; else if (rd) m_ovf = 1'b0;
`else
    if (rd) m_rdata = '0;
    if (drop) m_ovf = 1'b1;
`endif
    if (hs) begin
      logic [9:0] h;
      h = sb.pop_front();
      hs_cnt++;
      case (h[9:8])
        2'd0: m_c = h[7:0];
        2'd1: m_e = h[7:0];
        default: m_f = h[7:0];
      endcase
    end
    if (pushq && !drop) sb.push_back({psel, cpu_wdata});
    if (cpu_we && cpu_addr == 16'h4015) m_ne = cpu_wdata[3];
    check("wr_valid", wr_valid, sb.size() != 0);
    check("cpu_busy", cpu_busy, sb.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    check("r400c", r400c, m_c);
    check("r400e", r400e, m_e);
    check("r400f", r400f, m_f);
    check("noise_en", noise_en, m_ne);
    check("cpu_rdata", cpu_rdata, m_rdata);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic rd4015();
    cpu_addr = 16'h4015; cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, wr_valid, 1'b0);
    check({tag, "_busy"},  cpu_busy, 1'b0);
    check({tag, "_ovf"},   overflow, 1'b0);
    check({tag, "_shadow"}, {r400c, r400e, r400f}, 24'h0);
    check({tag, "_ne"},    noise_en, 1'b0);
    check({tag, "_rdata"}, cpu_rdata, 8'h00);
    check({tag, "_head"},  {wr_sel, wr_data}, 10'h0);
  endtask

  initial begin
    model_clear();
    #1 check_all_zero("rst0");
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single write with ack held: valid after the write edge, shadow one edge later.
    wr_ack = 1'b1;
    wr(16'h400E, 8'h85);
    check("t2_sel", wr_sel, 2'd1);
    check("t2_data", wr_data, 8'h85);
    tick();
    check("t2_r400e", r400e, 8'h85);
    check("t2_empty", wr_valid, 1'b0);

    // Fill while stalled; 5th write drops and sets overflow.
    wr_ack = 1'b0;
    wr(16'h400C, 8'h11); wr(16'h400C, 8'h22); wr(16'h400C, 8'h33); wr(16'h400C, 8'h44);
    check("t3_busy", cpu_busy, 1'b1);
    wr(16'h400C, 8'h55);
    check("t3_ovf", overflow, 1'b1);
    wr_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t3_drain", r400c, 8'(8'h11 * i));
    end
    check("t3_empty", wr_valid, 1'b0);

    // Push at the same edge as a pop while full: still dropped.
    wr_ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(16'h400F, 8'(i + 1));
    wr_ack = 1'b1;
    wr(16'h400E, 8'h77);
    tick(); tick(); tick(); tick();
    check("full_pop_drop_r400e", r400e, 8'h85);
    check("full_pop_drop_r400f", r400f, 8'h04);

    // Status readback (model yields 0 when the feature is built out).
    len_nonzero = 1'b1;
    rd4015();
    rd4015();
    len_nonzero = 1'b0;

    // $4015 noise enable, never queued.
    wr(16'h4015, 8'h08);
    check("t4_ne1", noise_en, 1'b1);
    check("t4_novalid", wr_valid, 1'b0);

    // Ignored addresses, then repeated $400F writes delivered separately.
    wr(16'h400D, 8'hAA);
    wr(16'h4010, 8'hBB);
    check("t5_ignored", wr_valid, 1'b0);
    hs_cnt = 0;
    wr(16'h400F, 8'h18);
    wr(16'h400F, 8'h18);
    tick(); tick();
    check("t5_two_hs", hs_cnt, 2);
    check("t5_r400f", r400f, 8'h18);

    // Mixed back-to-back traffic with random ack stalls.
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      wr_ack = 1'($urandom_range(0, 1));
      wr((k == 0) ? 16'h400C : (k == 1) ? 16'h400E : (k == 2) ? 16'h400F : 16'h400D,
         8'($urandom));
    end
    wr_ack = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();

    // Reset mid-run with entries queued and state nonzero.
    wr_ack = 1'b0;
    wr(16'h400C, 8'hC1); wr(16'h400E, 8'hC2); wr(16'h400F, 8'hC3);
    check("t1_queued", wr_valid, 1'b1);
    check("t1_ne_set", noise_en, 1'b1);
    #2 rst = 1'b1;
    #1 check_all_zero("t1_async");
    tick();
    #2 rst = 1'b0;
    wr_ack = 1'b1;
    tick(); tick();
    check("t1_post_shadow", {r400c, r400e, r400f}, 24'h0);
    check("t1_post_valid", wr_valid, 1'b0);
    wr(16'h4015, 8'hF7);
    check("t4_ne0", noise_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
